// File: rtl/ring_age_switch_allocator.sv
// ============================================================================
// Module   : ring_age_switch_allocator
// Purpose  : Oldest-first two-class output-port allocator with low-class aging.
//            Optional macro AGE_WRAP_EN selects wrap-tolerant timestamp compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_age_switch_allocator #(
  parameter logic [15:0] OUT_PORT     = 16'h0001,
  parameter int          PACKET_SIZE  = 49,
  parameter int          BUFFER_SIZE  = 4,
  parameter int          TS_LSB       = 32,
  parameter int          TS_WIDTH     = 16,
  parameter int          STARVE_LIMIT = 8,
  parameter int          POS_W        = $clog2(BUFFER_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PACKET_SIZE-1:0]             buffer_high_prior [BUFFER_SIZE],
  input  logic [15:0]                        buffer_high_prior_route_info [BUFFER_SIZE],
  input  logic [PACKET_SIZE-1:0]             buffer_low_prior [BUFFER_SIZE],
  input  logic [15:0]                        buffer_low_prior_route_info [BUFFER_SIZE],
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [PACKET_SIZE-1:0]             out_packet,
  output logic                               grant_valid,
  output logic [POS_W-1:0]                   grant_pos,
  output logic                               grant_in_high,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]  starve_cnt
);

  localparam int                 c_slots = 1 << POS_W;
  localparam int                 c_cnt_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

  typedef struct packed {
    logic             vld;
    logic [POS_W-1:0] idx;
  } pick_t;

  // True when timestamp a is strictly older than timestamp b.
  function automatic logic older(input logic [TS_WIDTH-1:0] a, input logic [TS_WIDTH-1:0] b);
`ifdef AGE_WRAP_EN
    logic [TS_WIDTH-1:0] diff;
    diff = a - b;
    return diff[TS_WIDTH-1];
`else
    return a < b;
`endif
  endfunction

  // Pairwise reduction over log2(c_slots) levels; the left (lower index) side
  // keeps the slot unless the right side is strictly older.
  function automatic pick_t pick_oldest(input logic [c_slots-1:0] elig,
                                        input logic [TS_WIDTH-1:0] ts [c_slots]);
    logic                vld  [c_slots];
    logic [TS_WIDTH-1:0] nts  [c_slots];
    logic [POS_W-1:0]    nidx [c_slots];
    pick_t               res;
    for (int i = 0; i < c_slots; i++) begin
      vld[i]  = elig[i];
      nts[i]  = ts[i];
      nidx[i] = POS_W'(i);
    end
    for (int s = 1; s < c_slots; s = s * 2) begin
      for (int i = 0; i + s < c_slots; i = i + 2 * s) begin
        if (vld[i+s] && (!vld[i] || older(nts[i+s], nts[i]))) begin
          vld[i]  = 1'b1;
          nts[i]  = nts[i+s];
          nidx[i] = nidx[i+s];
        end
      end
    end
    res.vld = vld[0];
    res.idx = nidx[0];
    return res;
  endfunction

  logic [c_slots-1:0]     w_high_elig;
  logic [c_slots-1:0]     w_low_elig;
  logic [TS_WIDTH-1:0]    w_high_ts [c_slots];
  logic [TS_WIDTH-1:0]    w_low_ts  [c_slots];
  pick_t                  w_high_pick;
  pick_t                  w_low_pick;
  logic                   w_cap;
  logic                   w_low_win;
  logic                   w_any;
  logic                   w_grant_valid;
  logic [PACKET_SIZE-1:0] w_win_packet;

  logic                   r_out_valid;
  logic [PACKET_SIZE-1:0] r_out_packet;
  logic [c_cnt_w-1:0]     r_starve_cnt;

  for (genvar i = 0; i < c_slots; i++) begin : g_leaf
    if (i < BUFFER_SIZE) begin : g_entry
      assign w_high_elig[i] = buffer_high_prior[i][PACKET_SIZE-1] &&
                              (buffer_high_prior_route_info[i] != 16'h0000);
      assign w_low_elig[i]  = buffer_low_prior[i][PACKET_SIZE-1] &&
                              (buffer_low_prior_route_info[i] == OUT_PORT);
      assign w_high_ts[i]   = buffer_high_prior[i][TS_LSB +: TS_WIDTH];
      assign w_low_ts[i]    = buffer_low_prior[i][TS_LSB +: TS_WIDTH];
    end else begin : g_pad
      assign w_high_elig[i] = 1'b0;
      assign w_low_elig[i]  = 1'b0;
      assign w_high_ts[i]   = '0;
      assign w_low_ts[i]    = '0;
    end
  end

  always_comb begin
    w_high_pick   = pick_oldest(w_high_elig, w_high_ts);
    w_low_pick    = pick_oldest(w_low_elig, w_low_ts);
    w_cap         = !r_out_valid || out_ready;
    w_low_win     = w_low_pick.vld && (!w_high_pick.vld || (r_starve_cnt == c_limit));
    w_any         = w_low_pick.vld || w_high_pick.vld;
    w_grant_valid = rst_n && w_cap && w_any;
    w_win_packet  = w_low_win ? buffer_low_prior[w_low_pick.idx]
                              : buffer_high_prior[w_high_pick.idx];
  end

  assign grant_valid   = w_grant_valid;
  assign grant_in_high = w_grant_valid && !w_low_win;
  assign grant_pos     = w_grant_valid ? (w_low_win ? w_low_pick.idx : w_high_pick.idx)
                                       : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_packet <= '0;
      r_starve_cnt <= '0;
    end else if (w_grant_valid) begin
      r_out_valid  <= 1'b1;
      r_out_packet <= w_win_packet;
      // Aging only advances when low was eligible but lost to high.
      if (!w_low_win && w_low_pick.vld) begin
        if (r_starve_cnt != c_limit) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end else if (w_cap) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_packet = r_out_packet;
  assign starve_cnt = r_starve_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ring_age_switch_allocator.sv
// ============================================================================
// Module   : tb_ring_age_switch_allocator
// Purpose  : Directed self-checking bench for ring_age_switch_allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_age_switch_allocator;

  logic        clk;
  logic        rst_n;
  logic [48:0] hp [4];
  logic [15:0] hr [4];
  logic [48:0] lp [4];
  logic [15:0] lr [4];
  logic        out_ready;
  logic        out_valid;
  logic [48:0] out_packet;
  logic        grant_valid;
  logic [1:0]  grant_pos;
  logic        grant_in_high;
  logic [1:0]  starve_cnt;

  int checks = 0;
  int errors = 0;

  ring_age_switch_allocator #(
    .OUT_PORT(16'h0001), .PACKET_SIZE(49), .BUFFER_SIZE(4), .TS_LSB(32),
    .TS_WIDTH(16), .STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .buffer_high_prior(hp), .buffer_high_prior_route_info(hr),
    .buffer_low_prior(lp), .buffer_low_prior_route_info(lr),
    .out_ready(out_ready), .out_valid(out_valid), .out_packet(out_packet),
    .grant_valid(grant_valid), .grant_pos(grant_pos),
    .grant_in_high(grant_in_high), .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] mk(input logic v, input logic [15:0] ts, input logic [31:0] d);
    return {v, ts, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < 4; i++) begin
      hp[i] = '0; hr[i] = '0; lp[i] = '0; lr[i] = '0;
    end
  endtask

  task automatic test_reset();
    clear_bufs();
    rst_n = 1'b0; out_ready = 1'b1;
    hp[1] = mk(1'b1, 16'h0003, 32'hAAAA_0001); hr[1] = 16'h0004;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_packet !== 49'h0) begin errors++; $display("FAIL reset_out_packet: got %h expected 0", out_packet); end
    checks++; if (starve_cnt !== 2'd0) begin errors++; $display("FAIL reset_starve: got %0d expected 0", starve_cnt); end
    checks++; if ({grant_valid, grant_pos, grant_in_high} !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", {grant_valid, grant_pos, grant_in_high}); end
    tick(); tick();
    rst_n = 1'b1;
    clear_bufs();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_high_oldest();
    logic [48:0] exp_pkt;
    clear_bufs();
    hp[2] = mk(1'b1, 16'h0010, 32'h0000_0A02); hr[2] = 16'h0003;
    hp[0] = mk(1'b1, 16'h0020, 32'h0000_0A00); hr[0] = 16'h0001;
    exp_pkt = hp[2];
    out_ready = 1'b1;
    #1;
    checks++; if ({grant_valid, grant_pos, grant_in_high} !== {1'b1, 2'd2, 1'b1}) begin errors++; $display("FAIL high_oldest_grant: got v=%b pos=%0d hi=%b expected v=1 pos=2 hi=1", grant_valid, grant_pos, grant_in_high); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL high_oldest_valid: got %b expected 1", out_valid); end
    checks++; if (out_packet !== exp_pkt) begin errors++; $display("FAIL high_oldest_packet: got %h expected %h", out_packet, exp_pkt); end
  endtask

  task automatic test_low_tie();
    logic [48:0] exp_pkt;
    clear_bufs();
    lp[1] = mk(1'b1, 16'h0005, 32'h0000_0B01); lr[1] = 16'h0001;
    lp[3] = mk(1'b1, 16'h0005, 32'h0000_0B03); lr[3] = 16'h0001;
    exp_pkt = lp[1];
    #1;
    checks++; if ({grant_valid, grant_pos, grant_in_high} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL low_tie_grant: got v=%b pos=%0d hi=%b expected v=1 pos=1 hi=0", grant_valid, grant_pos, grant_in_high); end
    tick();
    checks++; if (out_packet !== exp_pkt) begin errors++; $display("FAIL low_tie_packet: got %h expected %h", out_packet, exp_pkt); end
  endtask

  task automatic test_ineligible_drain();
    logic [48:0] exp_pkt;
    exp_pkt = lp[1];
    clear_bufs();
    lp[0] = mk(1'b1, 16'h0001, 32'h0000_0C00); lr[0] = 16'h0002;
    hp[1] = mk(1'b1, 16'h0001, 32'h0000_0C01); hr[1] = 16'h0000;
    hp[3] = mk(1'b0, 16'h0001, 32'h0000_0C03); hr[3] = 16'h0005;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL ineligible_grant: got %b expected 0", grant_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    checks++; if (out_packet !== exp_pkt) begin errors++; $display("FAIL drain_packet: got %h expected %h", out_packet, exp_pkt); end
  endtask

  task automatic test_hold();
    logic [48:0] pkt_a;
    logic [48:0] pkt_b;
    clear_bufs();
    pkt_a = mk(1'b1, 16'h0007, 32'h0000_D00A);
    pkt_b = mk(1'b1, 16'h0008, 32'h0000_D00B);
    hp[0] = pkt_a; hr[0] = 16'h0001;
    lp[0] = mk(1'b1, 16'h0003, 32'h0000_E000); lr[0] = 16'h0001;
    out_ready = 1'b1;
    #1;
    checks++; if (grant_in_high !== 1'b1) begin errors++; $display("FAIL class_priority: got hi=%b expected 1", grant_in_high); end
    tick();
    checks++; if (out_packet !== pkt_a) begin errors++; $display("FAIL hold_load: got %h expected %h", out_packet, pkt_a); end
    checks++; if (starve_cnt !== 2'd1) begin errors++; $display("FAIL hold_starve_inc: got %0d expected 1", starve_cnt); end
    out_ready = 1'b0;
    hp[0] = pkt_b;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL hold_grant[%0d]: got %b expected 0", c, grant_valid); end
      checks++; if ({out_valid, out_packet} !== {1'b1, pkt_a}) begin errors++; $display("FAIL hold_packet[%0d]: got %b/%h expected 1/%h", c, out_valid, out_packet, pkt_a); end
      checks++; if (starve_cnt !== 2'd1) begin errors++; $display("FAIL hold_starve[%0d]: got %0d expected 1", c, starve_cnt); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if ({grant_valid, grant_pos, grant_in_high} !== {1'b1, 2'd0, 1'b1}) begin errors++; $display("FAIL release_grant: got v=%b pos=%0d hi=%b expected v=1 pos=0 hi=1", grant_valid, grant_pos, grant_in_high); end
    tick();
    checks++; if (out_packet !== pkt_b) begin errors++; $display("FAIL release_packet: got %h expected %h", out_packet, pkt_b); end
    checks++; if (starve_cnt !== 2'd2) begin errors++; $display("FAIL release_starve: got %0d expected 2", starve_cnt); end
  endtask

  // Continues from test_hold: starve_cnt=2, high[0] and low[0] both eligible.
  task automatic test_starve_back_to_back();
    logic        exp_hi  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0]  exp_cnt [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [48:0] exp_pkt;
    for (int c = 0; c < 4; c++) begin
      exp_pkt = exp_hi[c] ? hp[0] : lp[0];
      #1;
      checks++; if ({grant_valid, grant_pos, grant_in_high} !== {1'b1, 2'd0, exp_hi[c]}) begin errors++; $display("FAIL starve_grant[%0d]: got v=%b pos=%0d hi=%b expected v=1 pos=0 hi=%b", c, grant_valid, grant_pos, grant_in_high, exp_hi[c]); end
      tick();
      checks++; if ({out_valid, out_packet} !== {1'b1, exp_pkt}) begin errors++; $display("FAIL b2b_packet[%0d]: got %b/%h expected 1/%h", c, out_valid, out_packet, exp_pkt); end
      checks++; if (starve_cnt !== exp_cnt[c]) begin errors++; $display("FAIL starve_cnt[%0d]: got %0d expected %0d", c, starve_cnt, exp_cnt[c]); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0]  exp_pos;
    logic [48:0] exp_pkt;
    clear_bufs();
    hp[0] = mk(1'b1, 16'hFFF0, 32'h0000_F000); hr[0] = 16'h0002;
    hp[1] = mk(1'b1, 16'h0005, 32'h0000_F001); hr[1] = 16'h0002;
    lp[2] = mk(1'b1, 16'h0100, 32'h0000_F102); lr[2] = 16'h0001;
`ifdef AGE_WRAP_EN
    exp_pos = 2'd0;
`else
    exp_pos = 2'd1;
`endif
    exp_pkt = hp[exp_pos];
    #1;
    checks++; if ({grant_valid, grant_pos, grant_in_high} !== {1'b1, exp_pos, 1'b1}) begin errors++; $display("FAIL wrap_grant: got v=%b pos=%0d hi=%b expected v=1 pos=%0d hi=1", grant_valid, grant_pos, grant_in_high, exp_pos); end
    tick();
    checks++; if (out_packet !== exp_pkt) begin errors++; $display("FAIL wrap_packet: got %h expected %h", out_packet, exp_pkt); end
    checks++; if (starve_cnt !== 2'd1) begin errors++; $display("FAIL wrap_starve: got %0d expected 1", starve_cnt); end
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_packet} !== 50'h0) begin errors++; $display("FAIL mid_reset_slot: got %b/%h expected 0/0", out_valid, out_packet); end
    checks++; if (starve_cnt !== 2'd0) begin errors++; $display("FAIL mid_reset_starve: got %0d expected 0", starve_cnt); end
    checks++; if ({grant_valid, grant_pos, grant_in_high} !== 4'b0) begin errors++; $display("FAIL mid_reset_grant: got %b expected 0000", {grant_valid, grant_pos, grant_in_high}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    clear_bufs();
    #1;
    test_reset();
    test_high_oldest();
    test_low_tie();
    test_ineligible_drain();
    test_hold();
    test_starve_back_to_back();
    test_wrap();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
